// File: rtl/scale_16to32b_pkg.sv
// Shared types and constants for the 16-to-32 bit upscaler.
// Holds the state encoding, the default widths and the saturation pattern.
package scale_pkg;

    localparam int DEF_IN_W   = 16;
    localparam int DEF_OUT_W  = 32;
    localparam int DEF_SHIFT  = 2;
    localparam int DEF_STEP_W = 4;

    // Wide enough for any practical OUT_W; truncated by the user
    localparam logic [63:0] SAT_ALL = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } scale_st_e;

    // Largest step count that cannot push a set bit out of the output word
    function automatic int max_steps(input int in_w, input int out_w, input int shift);
        return (out_w - in_w) / shift;
    endfunction

endpackage

// File: rtl/scale_16to32b_if.sv
// Request/result bundle between the scaling datapath and the upscaler.
// The master drives start/data/steps; the slave returns the restored value and status.
interface scale_16to32b_if #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STEP_W = 4
);
    logic              start_i;
    logic [IN_W-1:0]   data_i;
    logic [STEP_W-1:0] steps_i;
    logic [OUT_W-1:0]  y_o;
    logic              busy_o;
    logic              fl_o;
    logic              ovf_o;

    modport master (
        output start_i, data_i, steps_i,
        input  y_o, busy_o, fl_o, ovf_o
    );

    modport slave (
        input  start_i, data_i, steps_i,
        output y_o, busy_o, fl_o, ovf_o
    );
endinterface

// File: rtl/scale_16to32b_shl_step.sv
// N-bit register that can be loaded or shifted left by S bits per clock.
// Load wins over shift; zero fill, bits leaving the top are dropped.
module shl_step_n #(
    parameter int N = 32,
    parameter int S = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = d_i;
        end else if (shift_i) begin
            q_d = q_q << S;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/scale_16to32b.sv
// Upscaler control: accepts a scaled sample plus step count and drives the
// shift register for that many SHIFT-bit steps, saturating out-of-range requests.
//
//   state    | meaning
//   ST_IDLE  | no result yet since reset
//   ST_SHIFT | shifting, counter holds steps still to do
//   ST_DONE  | result valid on y_o/ovf_o, new start accepted
module scale_16to32b
    import scale_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    scale_16to32b_if.slave    bus
);

    localparam int                MAX_STEPS   = max_steps(IN_W, OUT_W, SHIFT);
    localparam logic [STEP_W-1:0] MAX_STEPS_C = STEP_W'(MAX_STEPS);
    localparam logic [OUT_W-1:0]  SAT_C       = OUT_W'(SAT_ALL);

    scale_st_e         state_q, state_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              load;
    logic              shift;
    logic [OUT_W-1:0]  load_val;
    logic [OUT_W-1:0]  y_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        load     = 1'b0;
        shift    = 1'b0;
        load_val = OUT_W'(bus.data_i);
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start_i) begin
                    load  = 1'b1;
                    ovf_d = 1'b0;
                    if (bus.steps_i == '0) begin
                        state_d = ST_DONE;
                    end else if (bus.steps_i > MAX_STEPS_C) begin
                        load_val = (bus.data_i != '0) ? SAT_C : '0;
                        ovf_d    = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d   = bus.steps_i;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == STEP_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    shl_step_n #(
        .N (OUT_W),
        .S (SHIFT)
    ) u_shl (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (load),
        .shift_i (shift),
        .d_i     (load_val),
        .q_o     (y_q)
    );

    assign bus.y_o    = y_q;
    assign bus.ovf_o  = ovf_q;
    assign bus.busy_o = (state_q == ST_SHIFT);
    assign bus.fl_o   = (state_q == ST_DONE);

endmodule

// File: tb/tb_scale_16to32b.sv
// Bench for scale_16to32b: expected results are queued when a start is driven
// and checked when the done flag appears.
module tb_scale_16to32b;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        int          lat;
        int          busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t sb[$];

    scale_16to32b_if #(.IN_W(16), .OUT_W(32), .STEP_W(4)) bus ();

    scale_16to32b dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [15:0] d, input logic [3:0] s);
        exp_t e;
        if (s == 4'd0) begin
            e.y = {16'h0, d}; e.ovf = 1'b0; e.lat = 1; e.busy = 0;
        end else if (s > 4'd8) begin
            e.y = (d != 16'h0) ? 32'hFFFF_FFFF : 32'h0; e.ovf = 1'b1; e.lat = 1; e.busy = 0;
        end else begin
            e.y = {16'h0, d} << (2 * int'(s)); e.ovf = 1'b0; e.lat = int'(s) + 1; e.busy = int'(s);
        end
        return e;
    endfunction

    task automatic run_op(input logic [15:0] d, input logic [3:0] s);
        exp_t e;
        int   edges;
        int   busy_cnt;
        bus.start_i = 1'b1;
        bus.data_i  = d;
        bus.steps_i = s;
        sb.push_back(model(d, s));
        tick();
        bus.start_i = 1'b0;
        edges    = 1;
        busy_cnt = int'(bus.busy_o);
        while (!bus.fl_o && edges < 40) begin
            tick();
            edges++;
            busy_cnt += int'(bus.busy_o);
        end
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL op_queue d=%h s=%0d: scoreboard empty", d, s);
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (bus.fl_o !== 1'b1) begin
            n_err++; $display("FAIL op_timeout d=%h s=%0d: fl_o=%b after %0d edges", d, s, bus.fl_o, edges);
        end
        n_vec++;
        if (edges !== e.lat) begin
            n_err++; $display("FAIL op_latency d=%h s=%0d: got %0d want %0d", d, s, edges, e.lat);
        end
        n_vec++;
        if (bus.y_o !== e.y) begin
            n_err++; $display("FAIL op_y d=%h s=%0d: got %h want %h", d, s, bus.y_o, e.y);
        end
        n_vec++;
        if (bus.ovf_o !== e.ovf) begin
            n_err++; $display("FAIL op_ovf d=%h s=%0d: got %b want %b", d, s, bus.ovf_o, e.ovf);
        end
        n_vec++;
        if (busy_cnt !== e.busy) begin
            n_err++; $display("FAIL op_busy d=%h s=%0d: got %0d want %0d", d, s, busy_cnt, e.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.data_i  = 16'h0;
        bus.steps_i = 4'h0;
        #23;
        n_vec++;
        if ({bus.y_o, bus.busy_o, bus.fl_o, bus.ovf_o} !== 35'h0) begin
            n_err++; $display("FAIL reset_outputs: got y=%h busy=%b fl=%b ovf=%b want all 0",
                              bus.y_o, bus.busy_o, bus.fl_o, bus.ovf_o);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({bus.busy_o, bus.fl_o} !== 2'b00) begin
            n_err++; $display("FAIL reset_idle: got busy=%b fl=%b want 0 0", bus.busy_o, bus.fl_o);
        end
    endtask

    task automatic test_basic_ops();
        run_op(16'hFFFF, 4'd8);
        run_op(16'h0001, 4'd0);
        run_op(16'h8001, 4'd1);
        run_op(16'hC3A5, 4'd7);
    endtask

    task automatic test_trace();
        logic [31:0] exp_seq [4];
        exp_seq = '{32'h0000_1234, 32'h0000_48D0, 32'h0001_2340, 32'h0004_8D00};
        bus.start_i = 1'b1;
        bus.data_i  = 16'h1234;
        bus.steps_i = 4'd3;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.start_i = 1'b0;
            n_vec++;
            if (bus.y_o !== exp_seq[k]) begin
                n_err++; $display("FAIL trace_y edge %0d: got %h want %h", k + 1, bus.y_o, exp_seq[k]);
            end
            n_vec++;
            if (bus.fl_o !== (k == 3)) begin
                n_err++; $display("FAIL trace_fl edge %0d: got %b want %b", k + 1, bus.fl_o, k == 3);
            end
        end
    endtask

    task automatic test_overflow();
        run_op(16'h0005, 4'd12);
        run_op(16'h0000, 4'd12);
        run_op(16'h0001, 4'd9);
        run_op(16'h7FFF, 4'd15);
        run_op(16'h0000, 4'd0);
    endtask

    task automatic test_ignored_start();
        int   edges;
        exp_t e;
        bus.start_i = 1'b1;
        bus.data_i  = 16'h00F3;
        bus.steps_i = 4'd5;
        sb.push_back(model(16'h00F3, 4'd5));
        tick();
        bus.start_i = 1'b0;
        tick();
        bus.start_i = 1'b1;
        bus.data_i  = 16'hAAAA;
        bus.steps_i = 4'd1;
        tick();
        bus.start_i = 1'b0;
        edges = 3;
        while (!bus.fl_o && edges < 40) begin
            tick();
            edges++;
        end
        e = sb.pop_front();
        n_vec++;
        if (edges !== 6) begin
            n_err++; $display("FAIL ignore_latency: got %0d edges want 6", edges);
        end
        n_vec++;
        if (bus.y_o !== e.y) begin
            n_err++; $display("FAIL ignore_y: got %h want %h", bus.y_o, e.y);
        end
        bus.start_i = 1'b1;
        bus.data_i  = 16'h0101;
        bus.steps_i = 4'd1;
        tick();
        bus.start_i = 1'b0;
        n_vec++;
        if ({bus.fl_o, bus.busy_o} !== 2'b01) begin
            n_err++; $display("FAIL done_restart: got fl=%b busy=%b want fl=0 busy=1", bus.fl_o, bus.busy_o);
        end
        tick();
        n_vec++;
        if (bus.fl_o !== 1'b1 || bus.y_o !== 32'h0000_0404) begin
            n_err++; $display("FAIL done_restart_result: got fl=%b y=%h want fl=1 y=00000404", bus.fl_o, bus.y_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] dv [3];
        exp_t        e;
        int          edges;
        dv = '{16'h00A1, 16'h0B0C, 16'hF00D};
        bus.start_i = 1'b1;
        bus.steps_i = 4'd2;
        bus.data_i  = dv[0];
        sb.push_back(model(dv[0], 4'd2));
        for (int i = 0; i < 3; i++) begin
            edges = 0;
            do begin
                tick();
                edges++;
            end while (!bus.fl_o && edges < 40);
            e = sb.pop_front();
            n_vec++;
            if (edges !== 3 || bus.y_o !== e.y) begin
                n_err++; $display("FAIL b2b op %0d: got edges=%0d y=%h want edges=3 y=%h", i, edges, bus.y_o, e.y);
            end
            if (i < 2) begin
                bus.data_i = dv[i + 1];
                sb.push_back(model(dv[i + 1], 4'd2));
            end else begin
                bus.start_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.start_i = 1'b1;
        bus.data_i  = 16'h00FF;
        bus.steps_i = 4'd6;
        sb.push_back(model(16'h00FF, 4'd6));
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.y_o, bus.busy_o, bus.fl_o, bus.ovf_o} !== 35'h0) begin
            n_err++; $display("FAIL mid_reset: got y=%h busy=%b fl=%b ovf=%b want all 0",
                              bus.y_o, bus.busy_o, bus.fl_o, bus.ovf_o);
        end
        sb.delete();
        #2;
        rst_n = 1'b1;
        tick();
        run_op(16'h4321, 4'd4);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_ops();
        test_trace();
        test_overflow();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
